instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 32 +++
 rtl/instr_loader.sv | 147 ++++++++++++++
 tb/tb_instr_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the serial instruction loader: FSM state encoding,
// default frame marker and the byte order used to lay words into memory.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN adds the CHECK state.
package instr_loader_pkg;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Words land big-endian: address 4w holds bits 31:24 of word w.
    localparam bit BYTE_ORDER_BIG_ENDIAN = 1'b1;

    // Loader FSM states; CHECK exists only when the checksum trailer is enabled.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Map the k-th payload byte of the stream onto its memory byte address.
    function automatic logic [7:0] byte_addr(input logic [7:0] k);
        if (BYTE_ORDER_BIG_ENDIAN) begin
            return k;
        end
        return {k[7:2], ~k[1:0]};
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Serial instruction loader: receives SYNC, LEN (word count), payload bytes
// and, optionally, an 8-bit checksum trailer from a valid/ready byte stream,
// writing the payload byte-wise into an external instruction memory.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN (checksum byte + CHECK state).
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int         MEM_BYTES = 44,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       core_run,
    output logic       load_err,
    output logic [3:0] words_loaded
);

    // Largest word count that still fits the memory; keeps addresses in range.
    localparam logic [8:0] MAX_WORDS = 9'(MEM_BYTES / 4);

    state_t     r_state;
    state_t     w_state_next;
    logic       w_accept;
    logic       w_len_ok;
    logic       w_last_byte;
    logic [7:0] r_last_idx;
    logic [7:0] r_byte_cnt;
    logic       r_mem_we;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_wdata;
    logic [3:0] r_words;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
`endif

    assign w_accept    = in_valid && in_ready;
    assign w_len_ok    = (in_data != 8'd0) && ({1'b0, in_data} <= MAX_WORDS);
    assign w_last_byte = (r_byte_cnt == r_last_idx);

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign words_loaded = r_words;

    // Status outputs decoded from state alone.
    always_comb begin
        in_ready = 1'b0;
        core_run = 1'b0;
        load_err = 1'b0;
        case (r_state)
            ST_IDLE, ST_LEN, ST_LOAD: in_ready = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CHECK:                 in_ready = 1'b1;
`endif
            ST_DONE:                  core_run = 1'b1;
            ST_ERR:                   load_err = 1'b1;
            default:                  in_ready = 1'b0;
        endcase
    end

    // Next-state logic; every transition is gated on an accepted byte.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (in_data == SYNC_BYTE)) begin
                    w_state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    w_state_next = w_len_ok ? ST_LOAD : ST_ERR;
                end
            end
            ST_LOAD: begin
                if (w_accept && w_last_byte) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    w_state_next = ST_CHECK;
`else
                    w_state_next = ST_DONE;
`endif
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_accept) begin
                    w_state_next = (in_data == r_csum) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: w_state_next = r_state;
        endcase
    end

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Byte counter, registered memory write port, word count and checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_idx  <= 8'd0;
            r_byte_cnt  <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_wdata <= 8'd0;
            r_words     <= 4'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept && (r_state == ST_LEN) && w_len_ok) begin
                // Index of the final payload byte, 4N-1 (N <= 63 by the bound).
                r_last_idx <= {in_data[5:0], 2'b00} - 8'd1;
                r_byte_cnt <= 8'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                r_csum     <= 8'd0;
`endif
            end
            if (w_accept && (r_state == ST_LOAD)) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= byte_addr(r_byte_cnt);
                r_mem_wdata <= in_data;
                r_byte_cnt  <= r_byte_cnt + 8'd1;
                if (r_byte_cnt[1:0] == 2'b11) begin
                    r_words <= r_words + 4'd1;
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                r_csum <= r_csum + in_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader. Follows the build's
// INSTR_LOADER_CHECKSUM_EN setting when deciding whether to send a trailer.
module tb_instr_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_run;
    logic       load_err;
    logic [3:0] words_loaded;

    int checks = 0;
    int errors = 0;

    // Write log captured away from the active edge.
    logic [7:0] wr_addr [0:255];
    logic [7:0] wr_data [0:255];
    logic [3:0] wr_wl   [0:255];
    int         wr_total = 0;

    logic [7:0] payload [0:63];

    instr_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_run     (core_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr[wr_total] <= mem_addr;
            wr_data[wr_total] <= mem_wdata;
            wr_wl[wr_total]   <= words_loaded;
            wr_total          <= wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
        tick(1);
        in_valid = 1'b0;
    endtask

    // Sends payload[0..cnt-1]; with gap set, one idle cycle follows each byte.
    task automatic send_payload(input int cnt, input bit gap);
        for (int i = 0; i < cnt; i++) begin
            send_byte(payload[i]);
            if (gap) tick(1);
        end
    endtask

    function automatic logic [7:0] payload_sum(input int cnt);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < cnt; i++) s = s + payload[i];
        return s;
    endfunction

    task automatic check_writes(input string tag, input int base, input int cnt);
        check({tag, "_count"}, 32'(wr_total - base), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            check({tag, "_addr"}, 32'(wr_addr[base + i]), 32'(i));
            check({tag, "_data"}, 32'(wr_data[base + i]), 32'(payload[i]));
        end
    endtask

    initial begin
        int base;

        // Reset state
        do_reset();
        check("rst_in_ready",  32'(in_ready),     32'd1);
        check("rst_mem_we",    32'(mem_we),       32'd0);
        check("rst_mem_addr",  32'(mem_addr),     32'd0);
        check("rst_mem_wdata", 32'(mem_wdata),    32'd0);
        check("rst_core_run",  32'(core_run),     32'd0);
        check("rst_load_err",  32'(load_err),     32'd0);
        check("rst_words",     32'(words_loaded), 32'd0);

        // Frame A: one word DE AD BE EF
        base = wr_total;
        payload[0] = 8'hDE; payload[1] = 8'hAD; payload[2] = 8'hBE; payload[3] = 8'hEF;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(payload[0]);
        check("a_we_after_first", 32'(mem_we),   32'd1);
        check("a_addr_first",     32'(mem_addr), 32'd0);
        tick(1);
        check("a_we_idle", 32'(mem_we), 32'd0);
        send_byte(payload[1]);
        send_byte(payload[2]);
        send_byte(payload[3]);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check("a_checksum_model", 32'(payload_sum(4)), 32'h38);
        send_byte(payload_sum(4));
`endif
        tick(2);
        check_writes("a", base, 4);
        check("a_wl_before_word", 32'(wr_wl[base + 2]), 32'd0);
        check("a_wl_with_word",   32'(wr_wl[base + 3]), 32'd1);
        check("a_words",    32'(words_loaded), 32'd1);
        check("a_core_run", 32'(core_run),     32'd1);
        check("a_load_err", 32'(load_err),     32'd0);
        check("a_in_ready", 32'(in_ready),     32'd0);
        // A byte offered in DONE must never be consumed
        base = wr_total;
        in_valid = 1'b1; in_data = 8'h55;
        tick(3);
        in_valid = 1'b0;
        check("a_done_no_write", 32'(wr_total - base), 32'd0);
        check("a_done_hold",     32'(core_run),        32'd1);

        // Frame B: leading junk, two words 01..08
        do_reset();
        base = wr_total;
        for (int i = 0; i < 8; i++) payload[i] = 8'(i + 1);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_payload(8, 1'b0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(payload_sum(8));
`endif
        tick(2);
        check_writes("b", base, 8);
        check("b_words",    32'(words_loaded), 32'd2);
        check("b_core_run", 32'(core_run),     32'd1);

        // Length out of range, then zero length
        do_reset();
        base = wr_total;
        send_byte(8'hA5);
        send_byte(8'h0C);
        tick(2);
        check("len12_err",      32'(load_err),        32'd1);
        check("len12_run",      32'(core_run),        32'd0);
        check("len12_ready",    32'(in_ready),        32'd0);
        check("len12_no_write", 32'(wr_total - base), 32'd0);
        do_reset();
        base = wr_total;
        send_byte(8'hA5);
        send_byte(8'h00);
        tick(2);
        check("len0_err",      32'(load_err),        32'd1);
        check("len0_no_write", 32'(wr_total - base), 32'd0);

        // Wrong checksum (sum is 0xAA, 0x00 sent when enabled)
        do_reset();
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33; payload[3] = 8'h44;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_payload(4, 1'b0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h00);
        tick(2);
        check("badck_err", 32'(load_err), 32'd1);
        check("badck_run", 32'(core_run), 32'd0);
`else
        tick(2);
        check("nock_run", 32'(core_run), 32'd1);
        check("nock_err", 32'(load_err), 32'd0);
`endif

        // Full 11-word frame with in_valid gaps
        do_reset();
        base = wr_total;
        for (int i = 0; i < 44; i++) payload[i] = 8'(i * 5 + 3);
        send_byte(8'hA5);
        tick(1);
        send_byte(8'h0B);
        tick(1);
        send_payload(44, 1'b1);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(payload_sum(44));
`endif
        tick(2);
        check_writes("full", base, 44);
        check("full_last_addr", 32'(wr_addr[base + 43]), 32'd43);
        check("full_words",     32'(words_loaded),       32'd11);
        check("full_core_run",  32'(core_run),           32'd1);

        // Reset after 5th payload byte, with a handshake during reset
        do_reset();
        base = wr_total;
        for (int i = 0; i < 8; i++) payload[i] = 8'(8'h80 + i);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_payload(5, 1'b0);
        in_valid = 1'b1; in_data = 8'hA5;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        in_valid = 1'b0;
        check("abort_writes",   32'(wr_total - base), 32'd5);
        check("abort_in_ready", 32'(in_ready),        32'd1);
        check("abort_we",       32'(mem_we),          32'd0);
        check("abort_addr",     32'(mem_addr),        32'd0);
        check("abort_wdata",    32'(mem_wdata),       32'd0);
        check("abort_words",    32'(words_loaded),    32'd0);
        check("abort_run",      32'(core_run),        32'd0);
        check("abort_err",      32'(load_err),        32'd0);
        tick(3);
        check("abort_no_more",  32'(wr_total - base), 32'd5);
        base = wr_total;
        payload[0] = 8'h01; payload[1] = 8'h02; payload[2] = 8'h03; payload[3] = 8'h04;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_payload(4, 1'b0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(payload_sum(4));
`endif
        tick(2);
        check_writes("fresh", base, 4);
        check("fresh_run", 32'(core_run),     32'd1);
        check("fresh_err", 32'(load_err),     32'd0);
        check("fresh_wl",  32'(words_loaded), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
